// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: default widths, the guard-bit
// width derivation, saturation bounds and common sample/accumulator types.
package fir_pkg;

    localparam int FIR_DATA_WIDTH  = 18;
    localparam int FIR_COEFF_WIDTH = 18;
    localparam int FIR_N_TAPS      = 4;

    // Full-precision accumulator width: product width plus one guard bit per
    // doubling of the tap count, so the tap sum can never wrap.
    function automatic int calc_in_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    localparam int FIR_IN_WIDTH = calc_in_width(FIR_DATA_WIDTH, FIR_COEFF_WIDTH, FIR_N_TAPS);

    localparam logic signed [FIR_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(FIR_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [FIR_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(FIR_DATA_WIDTH-1){1'b0}}};

    typedef logic signed [FIR_DATA_WIDTH-1:0] sample_t;
    typedef logic signed [FIR_IN_WIDTH-1:0]   acc_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count. The head entry is always
// presented on rd_data while rd_valid is high; rd_en pops it. Depth must be a
// power of two so the pointers wrap naturally.
module fir_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // A pop is only honoured with data present; a push at full is only
    // honoured when the head leaves in the same cycle.
    assign pop      = rd_en && (count != '0);
    assign push     = wr_en && ((count != FULL_COUNT) || pop);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_result_requant.sv
// Requantizer after the FIR core: rounds (half toward +inf), arithmetic-shifts
// and saturates the full-precision result down to sample width, then buffers
// it in a show-ahead FIFO behind a valid/ready output. in_ready is a
// conservative credit back to the FIR enable logic; anything offered without
// credit is dropped and latched in the sticky overflow flag.
// Optional build macro FIR_REQUANT_SAT_COUNT_EN adds a saturating 16-bit count
// of saturation events on sat_count; without it sat_count is tied to zero.
module fir_result_requant
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = FIR_DATA_WIDTH,
    parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
    parameter int N_TAPS      = FIR_N_TAPS,
    parameter int IN_WIDTH    = calc_in_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS),
    parameter int SHIFT       = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [IN_WIDTH-1:0]   in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         sat_flag,
    output logic                         overflow,
    output logic [15:0]                  sat_count
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WIDE_W = IN_WIDTH + 1;

    // One extra bit of headroom keeps the rounding add from wrapping.
    localparam logic signed [WIDE_W-1:0] ROUND_BIAS = {{(WIDE_W-1){1'b0}}, 1'b1} << (SHIFT-1);

    localparam logic signed [WIDE_W-1:0] SAT_HI_W = {{(WIDE_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_LO_W = {{(WIDE_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_HI_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_LO_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [CNT_W:0] FULL_LEVEL = (CNT_W+1)'(FIFO_DEPTH);

    logic signed [WIDE_W-1:0]     in_wide;
    logic signed [WIDE_W-1:0]     rounded;
    logic signed [WIDE_W-1:0]     s1_data;
    logic                         s1_valid;
    logic                         accept;
    logic                         sat_hi;
    logic                         sat_lo;
    logic                         sat_event;
    logic signed [DATA_WIDTH-1:0] sat_data;
    logic [CNT_W-1:0]             fifo_count;

    assign in_wide = {in_data[IN_WIDTH-1], in_data};
    assign rounded = (in_wide + ROUND_BIAS) >>> SHIFT;

    // The sample in stage 1 already owns a FIFO slot, and a same-cycle pop is
    // not credited, so the FIFO can never be written while full.
    assign in_ready = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid}) < FULL_LEVEL;
    assign accept   = in_valid && in_ready;

    // Stage 1: capture the rounded, shifted result on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= rounded;
            end
        end
    end

    // Stage 2: clamp the stage-1 value into the signed sample range.
    always_comb begin
        sat_hi   = (s1_data > SAT_HI_W);
        sat_lo   = (s1_data < SAT_LO_W);
        sat_data = s1_data[DATA_WIDTH-1:0];
        if (sat_hi) begin
            sat_data = SAT_HI_D;
        end else if (sat_lo) begin
            sat_data = SAT_LO_D;
        end
    end

    assign sat_event = s1_valid && (sat_hi || sat_lo);

    // Saturation pulse aligned with the FIFO write, and sticky drop detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sat_flag <= sat_event;
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef FIR_REQUANT_SAT_COUNT_EN
    logic [15:0] sat_cnt_q;

    // Count saturation events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt_q <= 16'd0;
        end else if (sat_event && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 16'd0;
`endif

    fir_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (s1_valid),
        .wr_data  (sat_data),
        .rd_en    (out_ready),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_fir_result_requant.sv
// Bench for fir_result_requant: a negedge monitor pushes model results for
// every accepted input and pops/compares them on every output handshake,
// while the directed phases check latency, flags and flow control.
`timescale 1ns/1ps
module tb_fir_result_requant;
    import fir_pkg::*;

    localparam int DW    = FIR_DATA_WIDTH;
    localparam int IW    = FIR_IN_WIDTH;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;
    localparam longint MAXV = 131071;
    localparam longint MINV = -131072;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [IW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    sample_t              out_data;
    logic                 sat_flag;
    logic                 overflow;
    logic [15:0]          sat_count;

    int     testsRun    = 0;
    int     testsFailed = 0;
    int     popCount    = 0;
    longint sb[$];

    longint rndIn[4]  = '{40, 24, -40, -24};
    longint rndExp[4] = '{3, 2, -2, -1};
    longint satIn[2]  = '{1073741824, -1073741824};
    longint satExp[2] = '{131071, -131072};
    longint rmIn[6]   = '{1600, 1073741824, 4800, 6400, 8000, 9600};

    int     valids;
    int     notReady;
    int     startPop;
    int     stale;
    bit     prevStalled;
    longint prevData;
    longint expSatCount;

    always #5 clk = ~clk;

    fir_result_requant #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (FIR_COEFF_WIDTH),
        .N_TAPS      (FIR_N_TAPS),
        .IN_WIDTH    (IW),
        .SHIFT       (SHIFT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .overflow  (overflow),
        .sat_count (sat_count)
    );

    // Reference: round half up, arithmetic shift, clamp to the sample range.
    function automatic longint modelRequant(input longint x);
        longint r;
        r = (x + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input longint data);
        in_valid = valid;
        in_data  = data[IW-1:0];
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty_at_pop", sb.size(), 1);
                end else begin
                    checkOutput("out_data", out_data, sb.pop_front());
                    popCount++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(modelRequant(longint'(in_data)));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_sat_flag", sat_flag, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_sat_count", sat_count, 0);
        reset = 1'b0;
        tick();

        // Rounding: single samples, two-cycle latency, no saturation.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, rndIn[i]);
            tick();
            applyStimulus(0, 0);
            checkOutput("rnd_early", out_valid, 0);
            tick();
            checkOutput("rnd_valid", out_valid, 1);
            checkOutput("rnd_data", out_data, rndExp[i]);
            checkOutput("rnd_sat_flag", sat_flag, 0);
            tick();
        end

        // Saturation: one sat_flag pulse per clamped sample.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, satIn[i]);
            tick();
            applyStimulus(0, 0);
            checkOutput("sat_flag_early", sat_flag, 0);
            tick();
            checkOutput("sat_valid", out_valid, 1);
            checkOutput("sat_data", out_data, satExp[i]);
            checkOutput("sat_flag_pulse", sat_flag, 1);
            tick();
            checkOutput("sat_flag_once", sat_flag, 0);
        end
`ifdef FIR_REQUANT_SAT_COUNT_EN
        expSatCount = 2;
`else
        expSatCount = 0;
`endif
        checkOutput("sat_count", sat_count, expSatCount);

        // Backpressure: four accepts fill the credit, the rest are dropped.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, i * 16);
            checkOutput("bp_in_ready", in_ready, (i <= 4));
            tick();
        end
        applyStimulus(0, 0);
        checkOutput("bp_overflow", overflow, 1);
        checkOutput("bp_full_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_no_gap", out_valid, 1);
            checkOutput("bp_order", out_data, k + 1);
            tick();
        end
        checkOutput("bp_drained", out_valid, 0);
        checkOutput("bp_sb_empty", sb.size(), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("bp_overflow_cleared", overflow, 0);

        // Streaming: one sample per cycle through the pipe.
        valids   = 0;
        notReady = 0;
        startPop = popCount;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1, longint'(k) * 40013 - 2000000);
            if (!in_ready) notReady++;
            if (k == 1) checkOutput("stream_latency_early", out_valid, 0);
            if (k == 2) checkOutput("stream_latency_first", out_valid, 1);
            if (out_valid) valids++;
            tick();
        end
        applyStimulus(0, 0);
        for (int k = 0; k < 3; k++) begin
            if (out_valid) valids++;
            tick();
        end
        checkOutput("stream_valid_cycles", valids, 100);
        checkOutput("stream_pops", popCount - startPop, 100);
        checkOutput("stream_not_ready", notReady, 0);
        checkOutput("stream_overflow", overflow, 0);
        checkOutput("stream_sb_empty", sb.size(), 0);

        // Stall hold: head stays put while out_ready is low.
        out_ready = 1'b0;
        startPop  = popCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, (i + 1) * 1600 + 7);
            tick();
        end
        applyStimulus(0, 0);
        tick();
        prevStalled = 1'b0;
        prevData    = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && sb.size() > 0) checkOutput("stall_head", out_data, sb[0]);
            if (prevStalled) checkOutput("stall_hold", out_data, prevData);
            out_ready   = (c % 3 == 2);
            prevStalled = out_valid && !out_ready;
            prevData    = longint'(out_data);
            tick();
        end
        out_ready = 1'b1;
        repeat (6) tick();
        checkOutput("stall_pops", popCount - startPop, 4);
        checkOutput("stall_sb_empty", sb.size(), 0);

        // Reset mid-stream: 3 buffered, 1 in stage 1, overflow already set.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, rmIn[i]);
            tick();
        end
        applyStimulus(0, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        applyStimulus(1, 777 * 16);
        checkOutput("rm_in_ready", in_ready, 1);
        tick();
        applyStimulus(0, 0);
        checkOutput("rm_overflow_set", overflow, 1);
`ifdef FIR_REQUANT_SAT_COUNT_EN
        expSatCount = 1;
`else
        expSatCount = 0;
`endif
        checkOutput("rm_sat_count_pre", sat_count, expSatCount);
        reset = 1'b1;
        #1;
        checkOutput("rm_out_valid", out_valid, 0);
        checkOutput("rm_in_ready_rst", in_ready, 1);
        checkOutput("rm_overflow_clr", overflow, 0);
        checkOutput("rm_sat_count_clr", sat_count, 0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) stale++;
            tick();
        end
        checkOutput("rm_no_stale", stale, 0);
        checkOutput("rm_overflow_after", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fir_result_requant.md
Name: fir_result_requant

Overview:
- Consumer-side block for the FIR datapath. Takes the full-precision signed FIR result stream and rounds, shifts and saturates it back to sample width.
- Results are buffered in a small FIFO and presented on a valid/ready output interface, so downstream logic can apply backpressure.
- Flow-control status goes back toward the FIR enable logic.
- Sits directly after the FIR core, before any narrow-width sink (DAC, decimator, bus bridge).

Parameters:
- DATA_WIDTH, 18, FIR sample width; output width
- COEFF_WIDTH, 18, FIR coefficient width
- N_TAPS, 4, FIR tap count; sets guard bits
- IN_WIDTH, DATA_WIDTH+COEFF_WIDTH+$clog2(N_TAPS) (38), input result width
- SHIFT, 4, right-shift amount applied after rounding; legal range 1..IN_WIDTH-DATA_WIDTH
- FIFO_DEPTH, 4, output buffer entries; power of two, >=2

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  FIR result valid this cycle (driven from FIR ena)
- in_data  input  IN_WIDTH  signed FIR result
- in_ready  output  1  room for one more result (credit to FIR enable logic)
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  downstream accepts sample
- out_data  output  DATA_WIDTH  signed requantized sample
- sat_flag  output  1  one-cycle pulse when a saturated value is written to the FIFO
- overflow  output  1  sticky: input arrived while in_ready=0
- sat_count  output  16  saturation event count (see Optional Feature)

Behaviour:
- Reset: asynchronous and active-high, with no sync release logic inside the block. While reset=1 and after it:
  - FIFO empty, stage-1 register invalid
  - out_valid=0, out_data=0, sat_flag=0, overflow=0, sat_count=0, in_ready=1
- Reset mid-operation discards all in-flight and buffered samples.
- Accept rule: a sample is accepted when in_valid & in_ready.
- Drop rule: in_valid & !in_ready drops the sample (nothing enters the pipe) and sets overflow. overflow stays set until reset.
- Stage 1, registered on the accept edge:
  - r = (in_data + 2^(SHIFT-1)) >>> SHIFT
  - Arithmetic shift; round half toward +inf.
  - Computed at IN_WIDTH+1 bits, so the rounding add cannot wrap.
- Stage 2, combinational saturate feeding the FIFO write:
  - Clamp r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Written on the next edge; sat_flag pulses in the same cycle the write is registered.
- Latency: sample accepted in cycle N is written at the end of cycle N+1. If the FIFO was empty, out_valid=1 with that data in cycle N+2.
- FIFO:
  - Show-ahead; out_data is registered FIFO head.
  - Pop on out_valid & out_ready.
  - out_data holds its value while out_valid & !out_ready.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Count width is $clog2(FIFO_DEPTH)+1.
- in_ready = (fifo_count + s1_valid) < FIFO_DEPTH.
  - Conservative: a same-cycle pop is not credited.
  - Hence the FIFO never overflows internally.
- Simultaneous push and pop:
  - At count=FIFO_DEPTH: legal, count unchanged.
  - At count=0: push data is visible the cycle after; no bypass.
- Back-to-back accepts every cycle sustain one sample/cycle while out_ready=1.

Optional Feature:
- Macro: FIR_REQUANT_SAT_COUNT_EN
- Defined:
  - sat_count is a 16-bit counter incremented on each sat_flag pulse.
  - It saturates at 0xFFFF and does not wrap.
  - Cleared only by reset.
- Undefined: counter logic is not built and sat_count is tied to 0. sat_flag behaviour is unchanged.

Decomposition:
- Package fir_pkg:
  - DATA_WIDTH/COEFF_WIDTH/N_TAPS defaults
  - IN_WIDTH derivation function
  - Saturation bound constants (SAT_MAX, SAT_MIN)
  - typedef sample_t (signed DATA_WIDTH)
  - typedef acc_t (signed IN_WIDTH)
- One sub-module: fir_sync_fifo, parameterized by width and depth, show-ahead, with count output. It is reusable elsewhere in the FIR chain.
- Rounding and saturation stay inline in the top.

Test Plan (SHIFT=4, DATA_WIDTH=18):
- Rounding:
  - in_data=40 -> out_data=3
  - in_data=24 -> 2 (half rounds up)
  - in_data=-40 -> -2
  - in_data=-24 -> -1
  - Each appears 2 cycles after accept; sat_flag=0.
- Saturation:
  - in_data=2^30 -> 131071
  - in_data=-2^30 -> -131072
  - sat_flag pulses once per sample; with macro defined, sat_count=2.
- Backpressure: out_ready=0, 6 consecutive valid inputs (1..6 scaled by 16):
  - in_ready drops after 4 accepts; samples 5-6 dropped; overflow=1.
  - Then out_ready=1 -> outputs 1,2,3,4 in order, no gaps.
- Streaming: out_ready=1, in_valid=1 for 100 cycles of a ramp:
  - 100 outputs, one per cycle, after 2-cycle latency.
  - in_ready stays 1; overflow stays 0.
- Stall hold: out_valid=1, out_ready toggled 0/1 -> out_data stable while stalled, no duplicates or losses.
- Reset mid-stream: assert reset with 3 samples buffered and 1 in stage 1 -> out_valid=0 immediately (async). No stale sample appears after release; overflow and sat_count cleared.
